// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the multi-cycle CPU.
// It latches one load/store request, waits WAIT_CYCLES cycles, and then
// commits the store or returns the load word with a one-cycle ready pulse.
// Storage is a big-endian byte array of DEPTH_BYTES entries. Addresses wrap
// modulo DEPTH_BYTES.
// Optional feature macro: DMEM_ALIGN_CHECK_EN. It adds the err port. A
// misaligned access then performs no write and returns rdata=0 with err=1.
// Without the macro, addr[1:0] is ignored and every access is word-aligned.
// Memory contents are not touched by Reset. They rely on the zero power-up
// contents of the target storage.

module dmem_responder #(
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        DataMemRW,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int         AW       = $clog2(DEPTH_BYTES);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_rw;
    logic [31:0]   r_rdata;
    logic [7:0]    r_mem [DEPTH_BYTES];

    logic          w_accept;
    logic          w_enter_resp;
    logic [AW-1:0] w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic          w_acc_rw;
    logic [AW-1:0] w_base;
    logic [31:0]   w_word;
    logic          w_bad;
    logic          w_unused_addr;

    // Bits above the memory size only select an aliased copy of the array.
    assign w_unused_addr = ^addr[31:AW];

    assign w_accept     = (r_state == S_IDLE) && req;
    assign w_enter_resp = (r_state != S_RESP) && (w_state_nxt == S_RESP);

    // With WAIT_CYCLES=0 the commit happens on the accepting edge itself,
    // so the access fields come straight from the inputs while IDLE.
    assign w_acc_addr  = (r_state == S_IDLE) ? addr[AW-1:0] : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? wdata        : r_wdata;
    assign w_acc_rw    = (r_state == S_IDLE) ? DataMemRW    : r_rw;

    // Word base: byte index with the two low bits cleared.
    assign w_base = w_acc_addr & ~AW'(3);
    assign w_word = {r_mem[w_base],
                     r_mem[w_base + AW'(1)],
                     r_mem[w_base + AW'(2)],
                     r_mem[w_base + AW'(3)]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_bad = |w_acc_addr[1:0];
`else
    assign w_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts down, RESP lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: ready in RESP, busy whenever an access is in flight.
    always_comb begin
        ready = (r_state == S_RESP);
        busy  = (r_state != S_IDLE);
        rdata = r_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
        err   = (r_state == S_RESP) && w_bad;
`endif
    end

    // Capture the request fields on acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!Reset && w_accept) begin
            r_addr  <= addr[AW-1:0];
            r_wdata <= wdata;
            r_rw    <= DataMemRW;
        end
    end

    // Wait counter: loaded on acceptance, decremented while in WAIT.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Store commit on the edge entering RESP; an aborted access never writes.
    always_ff @(posedge clk) begin
        if (!Reset && w_enter_resp && w_acc_rw && !w_bad) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[w_base + AW'(i)] <= w_acc_wdata[31 - 8*i -: 8];
            end
        end
    end

    // Load data register: pre-write word while entering RESP, zero otherwise.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_rdata <= 32'd0;
        end else if (w_enter_resp && !w_bad) begin
            r_rdata <= w_word;
        end else begin
            r_rdata <= 32'd0;
        end
    end

endmodule
